// File: rtl/fft_out_streamer.sv
// rtl/fft_out_streamer.sv - snapshots each completed 512-sample reordered frame and streams it
// out as 32 beats of 16 samples under a valid/ready handshake, dropping frames that arrive while busy.
module fft_out_streamer #(
  parameter int DW    = 13,
  parameter int N     = 512,
  parameter int LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 di_en,
  input  logic signed [DW-1:0] din [0:N-1],
  output logic signed [DW-1:0] dout [0:LANES-1],
  output logic                 do_valid,
  input  logic                 do_ready,
  output logic                 do_sop,
  output logic                 do_eop,
  output logic                 do_ovf
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [4:0]           in_cnt_q, in_cnt_d;
  logic [4:0]           beat_q, beat_d;
  logic                 frame_rdy_q, frame_rdy_d;
  logic                 do_ovf_q, do_ovf_d;
  logic                 accept;
  logic                 capture;
  logic signed [DW-1:0] shadow_q [0:N-1];
  logic signed [DW-1:0] shadow_d [0:N-1];

  // Mirrors the reorder stage's write counter; the 32nd strobe completes a frame.
  always_comb begin
    in_cnt_d    = di_en ? in_cnt_q + 5'd1 : in_cnt_q;
    frame_rdy_d = di_en && (in_cnt_q == 5'd31);
  end

  assign do_valid = (state_q == STREAM);
  assign accept   = do_valid && do_ready;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    capture  = 1'b0;
    do_ovf_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_rdy_q) begin
          capture = 1'b1;
          beat_d  = 5'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept && beat_q == 5'd31) begin
          beat_d = 5'd0;
          if (frame_rdy_q) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept) begin
            beat_d = beat_q + 5'd1;
          end
          // The shadow is still in use; the new frame is lost.
          if (frame_rdy_q) begin
            do_ovf_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (capture) begin
      shadow_d = din;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= 5'd0;
      beat_q      <= 5'd0;
      frame_rdy_q <= 1'b0;
      do_ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      beat_q      <= beat_d;
      frame_rdy_q <= frame_rdy_d;
      do_ovf_q    <= do_ovf_d;
    end
  end

  // The overflow flag is registered so that no output depends on do_ready combinationally.
  assign do_ovf = do_ovf_q;
  assign do_sop = do_valid && (beat_q == 5'd0);
  assign do_eop = do_valid && (beat_q == 5'd31);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dout[i] = do_valid ? shadow_q[{beat_q, 4'(i)}] : '0;
    end
  end

endmodule

// File: tb/tb_fft_out_streamer.sv
// tb/tb_fft_out_streamer.sv - scoreboard bench for fft_out_streamer with a frame-level
// reference model: one shadow buffer, a new frame is taken only if the old one is fully consumed.
module tb_fft_out_streamer;

  localparam int DW = 13;
  localparam int N  = 512;
  localparam int L  = 16;

  typedef struct {
    int                    due;
    logic [N-1:0][DW-1:0]  d;
  } frm_t;

  typedef struct {
    logic [L-1:0][DW-1:0]  d;
    logic                  sop;
    logic                  eop;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 di_en;
  logic signed [DW-1:0] din [0:N-1];
  logic signed [DW-1:0] dout [0:L-1];
  logic                 do_valid;
  logic                 do_ready;
  logic                 do_sop;
  logic                 do_eop;
  logic                 do_ovf;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_on = 1'b0;
  int    scnt = 0;
  int    fmode = 0;
  int    fbase = 0;
  int    fstep = 0;
  int    ovf_due = -1;
  frm_t  frm_q [$];
  beat_t exp_q [$];

  fft_out_streamer #(.DW(DW), .N(N), .LANES(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .di_en    (di_en),
    .din      (din),
    .dout     (dout),
    .do_valid (do_valid),
    .do_ready (do_ready),
    .do_sop   (do_sop),
    .do_eop   (do_eop),
    .do_ovf   (do_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit en, input bit rdy, input bit r);
    frm_t f;
    @(posedge clk);
    #1;
    rst      = r;
    do_ready = rdy;
    di_en    = en && !r;
    if (r) begin
      scnt = 0;
    end else if (en) begin
      scnt++;
      if (scnt == 32) begin
        scnt = 0;
        for (int k = 0; k < N; k++) begin
          din[k] = (fmode == 0) ? DW'(k + fbase) : DW'($urandom);
          f.d[k] = din[k];
        end
        f.due = cyc + 1;
        frm_q.push_back(f);
        fbase += fstep;
      end else if (scnt >= 2) begin
        din[$urandom_range(0, N - 1)] = DW'($urandom);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      bit            ev;
      bit            bad;
      int            bl;
      logic [DW-1:0] e;
      frm_t          f;
      beat_t         bt;
      ev  = (exp_q.size() != 0);
      bad = 1'b0;
      bl  = 0;
      check("do_valid", 32'(do_valid), 32'(ev));
      check("do_sop", 32'(do_sop), ev ? 32'(exp_q[0].sop) : 32'd0);
      check("do_eop", 32'(do_eop), ev ? 32'(exp_q[0].eop) : 32'd0);
      check("do_ovf", 32'(do_ovf), 32'(ovf_due == cyc));
      for (int i = 0; i < L; i++) begin
        e = ev ? exp_q[0].d[i] : '0;
        if (dout[i] !== e && !bad) begin
          bad = 1'b1;
          bl  = i;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL dout cyc=%0d lane=%0d got=%0h expected=%0h", cyc, bl, dout[bl],
                 ev ? exp_q[0].d[bl] : '0);
      end
      if (rst) begin
        exp_q.delete();
        frm_q.delete();
        ovf_due = -1;
      end else begin
        if (ev && do_ready) void'(exp_q.pop_front());
        if (frm_q.size() != 0 && frm_q[0].due == cyc) begin
          f = frm_q.pop_front();
          if (exp_q.size() == 0) begin
            for (int b = 0; b < 32; b++) begin
              for (int i = 0; i < L; i++) bt.d[i] = f.d[16 * b + i];
              bt.sop = (b == 0);
              bt.eop = (b == 31);
              exp_q.push_back(bt);
            end
          end else begin
            ovf_due = cyc + 1;
          end
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    di_en    = 1'b0;
    do_ready = 1'b0;
    for (int k = 0; k < N; k++) din[k] = '0;

    step(0, 0, 1);
    mon_on = 1'b1;
    step(0, 0, 1);
    repeat (50) step(0, $urandom_range(0, 1) == 1, 0);

    fmode = 0; fbase = 0; fstep = 0;
    repeat (32) step(1, 1, 0);
    repeat (40) step(0, 1, 0);

    fbase = 0; fstep = 1000;
    repeat (64) step(1, 1, 0);
    repeat (40) step(0, 1, 0);

    fbase = 0; fstep = 0;
    for (int t = 0; t < 80; t++) step(t < 32, !(t >= 38 && t <= 42), 0);

    fbase = 7; fstep = 500;
    for (int t = 0; t < 80; t++) step(t < 32 || (t >= 40 && t < 72), t < 37, 0);
    repeat (40) step(0, 1, 0);

    fbase = 3; fstep = 0;
    for (int t = 0; t < 43; t++) step(t < 32, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    fbase = 100;
    repeat (32) step(1, 1, 0);
    repeat (40) step(0, 1, 0);

    fmode = 1;
    repeat (3000) step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
    repeat (80) step(0, 1, 0);

    check("drain_beats", 32'(exp_q.size()), 32'd0);
    check("drain_frames", 32'(frm_q.size()), 32'd0);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
